cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing controller for the 2-way set-associative, write-back, LRU data cache that sits between the CPU and the 1 KiB byte-addressed main memory.
- Owns the tag, valid, dirty and LRU state, and performs the hit/miss decision.
- Drives the cache data-array control strobes.
- Runs word-by-word victim write-back and refill bursts over a req/ack memory port.

Parameters:
- ADDR_W, 10, CPU/memory byte address width
- WORDS_PER_BLOCK, 4, 32-bit words per cache block
- NUM_SETS, 2, sets, each holding 2 ways
- Derived widths: offset 2 bits [1:0], word 2 bits [3:2], index 1 bit [4], tag 5 bits [9:5].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  CPU request present; held until accepted
- cpu_req_ready  out  1  controller accepts a request this cycle
- cpu_rw  in  1  1 = write, 0 = read; sampled on accept
- cpu_addr  in  ADDR_W  byte address; sampled on accept
- cpu_resp_valid  out  1  one-cycle pulse; access completed this cycle
- cpu_hit  out  1  hit (1) or miss (0) of the original lookup; valid with cpu_resp_valid
- da_en  out  1  data-array access strobe
- da_we  out  1  data-array word write enable
- da_wsel  out  1  write data source: 0 = CPU write data, 1 = mem_rdata
- da_way  out  1  way select
- da_set  out  1  set select
- da_word  out  2  word select
- mem_req  out  1  memory word request
- mem_we  out  1  1 = write (victim word supplied by the data-array read port), 0 = read
- mem_addr  out  ADDR_W  {tag, set, word, 2'b00}
- mem_ack  in  1  memory completes the current word; arbitrary latency

Behaviour:
- Reset (async, rst_n low): FSM enters IDLE.
  - All valid, dirty and LRU bits are cleared.
  - All outputs are 0, except cpu_req_ready = 1.
  - mem_req drops immediately; any in-flight burst is abandoned.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch rw, addr and go to LOOKUP.
  - cpu_req_ready = 0 in every other state.
- LOOKUP: compare the latched tag against both ways of the set, valid-qualified.
  - Hit: record hit = 1, go to RESPOND.
  - Miss: record hit = 0 and select the victim.
    - Victim is the first invalid way, way 0 preferred; otherwise the LRU way.
    - Victim valid and dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - For word = 0..3: da_en = 1, da_we = 0.
  - mem_req = 1, mem_we = 1, mem_addr = {victim tag, set, word, 00}.
  - mem_req, mem_we and mem_addr stay stable until mem_ack is sampled high; the word counter then advances.
  - After word 3 is acked: clear the victim's dirty bit, go to REFILL.
- REFILL:
  - For word = 0..3: mem_req = 1, mem_we = 0, mem_addr = {new tag, set, word, 00}.
  - On the mem_ack cycle: da_en = da_we = 1, da_wsel = 1, targeting the victim way.
  - After word 3: write the tag, set valid = 1 and dirty = 0, go to RESPOND.
- RESPOND:
  - da_en = 1, da_way = hit/filled way, da_set and da_word from the latched address.
  - Write access: da_we = 1, da_wsel = 0, set dirty.
  - Read access: data-array read data is valid this cycle.
  - cpu_resp_valid = 1 and cpu_hit = recorded hit.
  - Update LRU for the set so the accessed way becomes MRU; return to IDLE.
- Latency:
  - Hit: accept at cycle T, response at T+2.
  - Clean miss: T+2+(4 acked memory words)+1.
  - Dirty miss: adds 4 further acked words.
- Boundary conditions:
  - mem_ack while mem_req = 0 is ignored.
  - mem_ack in the same cycle mem_req first rises is accepted (zero-wait memory).
  - A cpu_req_valid presented while busy is not accepted; its fields are ignored until IDLE.
  - Word counter wraps 3 -> 0 only at burst end.
  - Both ways invalid: way 0 is chosen.
  - A write miss is write-allocate: refill, then write in RESPOND.
- Main memory is never written except in WRITEBACK (write-back policy).

Decomposition:
- Shared package cache_pkg holds:
  - Address field widths and positions (TAG_W, IDX_W, WORD_W, offset LSBs).
  - State enum encoding.
  - Address-compose function {tag, set, word, 00}.
- One natural sub-module: cache_tag_store, holding the tag, valid, dirty and LRU arrays.
  - Combinational hit/way/victim lookup.
  - Synchronous updates.
  - Asynchronous clear on rst_n.

Test Plan:
- After reset, read 0x000 -> miss; 4 memory reads at 0x000, 0x004, 0x008, 0x00C; resp at accept+2+4+1 with cpu_hit = 0; way 0 valid.
- Write 0x000 -> cpu_hit = 1, resp at accept+2, da_we = 1 and da_wsel = 0 in RESPOND; no mem_req asserted; set 0 way 0 dirty.
- Read 0x200 -> miss into way 1, no write-back; then read 0x000 -> cpu_hit = 1 (2-way keeps both blocks).
- Read 0x300 -> miss evicts way 1 (LRU, clean), no mem writes; then read 0x200 -> miss evicts dirty way 0:
  - 4 mem writes at 0x000..0x00C first, then 4 reads at 0x200..0x20C.
- Memory ack delayed 3 cycles per word with cpu_req_valid held high throughout -> mem_addr stable while waiting, cpu_req_ready = 0 until IDLE, exactly one response.
- rst_n pulled low mid-REFILL (after word 1 ack) -> mem_req = 0 immediately, no response; afterwards read 0x200 misses (valid cleared).

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache controller:
// address field layout, controller state encoding and memory address composition.
package cache_pkg;

  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned NUM_SETS        = 2;

  localparam int unsigned OFF_W  = 2;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned IDX_W  = 1;
  localparam int unsigned TAG_W  = 5;

  localparam int unsigned WORD_LSB = OFF_W;
  localparam int unsigned IDX_LSB  = OFF_W + WORD_W;
  localparam int unsigned TAG_LSB  = IDX_LSB + IDX_W;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_e;

  function automatic logic [ADDR_W-1:0] compose_addr(input logic [TAG_W-1:0]  tag,
                                                     input logic [IDX_W-1:0]  set,
                                                     input logic [WORD_W-1:0] word);
    return {tag, set, word, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag, valid, dirty and LRU state for both ways of every set, with
// combinational hit/victim lookup and synchronous updates.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] set_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             way_i,
  input  logic             fill_en_i,
  input  logic             clean_en_i,
  input  logic             touch_en_i,
  input  logic             touch_dirty_i,
  output logic             hit_o,
  output logic             hit_way_o,
  output logic             victim_way_o,
  output logic             victim_dirty_o,
  output logic [TAG_W-1:0] victim_tag_o
);

  logic [TAG_W-1:0]    tag_q   [NUM_SETS][2];
  logic [1:0]          valid_q [NUM_SETS];
  logic [1:0]          dirty_q [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;

  logic hit0, hit1;

  always_comb begin
    hit0      = valid_q[set_i][0] && (tag_q[set_i][0] == tag_i);
    hit1      = valid_q[set_i][1] && (tag_q[set_i][1] == tag_i);
    hit_o     = hit0 || hit1;
    hit_way_o = !hit0;
    // An invalid way is always preferred over evicting, way 0 first.
    if (!valid_q[set_i][0])      victim_way_o = 1'b0;
    else if (!valid_q[set_i][1]) victim_way_o = 1'b1;
    else                         victim_way_o = lru_q[set_i];
    victim_tag_o   = tag_q[set_i][victim_way_o];
    victim_dirty_o = valid_q[set_i][victim_way_o] && dirty_q[set_i][victim_way_o];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        tag_q[s][0] <= '0;
        tag_q[s][1] <= '0;
        valid_q[s]  <= '0;
        dirty_q[s]  <= '0;
      end
      lru_q <= '0;
    end else begin
      if (fill_en_i) begin
        tag_q[set_i][way_i]   <= tag_i;
        valid_q[set_i][way_i] <= 1'b1;
        dirty_q[set_i][way_i] <= 1'b0;
      end
      if (clean_en_i) dirty_q[set_i][way_i] <= 1'b0;
      if (touch_en_i) begin
        lru_q[set_i] <= ~way_i;
        if (touch_dirty_i) dirty_q[set_i][way_i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for the 2-way write-back LRU data cache: hit/miss
// decision, victim write-back and refill bursts, and data-array strobes.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_resp_valid,
  output logic              cpu_hit,
  output logic              da_en,
  output logic              da_we,
  output logic              da_wsel,
  output logic              da_way,
  output logic [IDX_W-1:0]  da_set,
  output logic [WORD_W-1:0] da_word,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack
);

  state_e              state_q;
  logic                rw_q, hit_q, way_q, mem_req_q;
  logic [TAG_W-1:0]    atag_q, vtag_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-1:0]   cword_q, bcnt_q;

  logic             ts_hit, ts_hit_way, ts_victim_way, ts_victim_dirty;
  logic [TAG_W-1:0] ts_victim_tag;
  logic             last_ack;
  logic             unused_off;

  assign unused_off = ^cpu_addr[OFF_W-1:0];
  assign last_ack   = mem_req_q && mem_ack && (bcnt_q == LAST_WORD);

  cache_tag_store u_tags (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_i          (idx_q),
    .tag_i          (atag_q),
    .way_i          (way_q),
    .fill_en_i      ((state_q == S_REFILL) && last_ack),
    .clean_en_i     ((state_q == S_WRITEBACK) && last_ack),
    .touch_en_i     (state_q == S_RESPOND),
    .touch_dirty_i  (rw_q),
    .hit_o          (ts_hit),
    .hit_way_o      (ts_hit_way),
    .victim_way_o   (ts_victim_way),
    .victim_dirty_o (ts_victim_dirty),
    .victim_tag_o   (ts_victim_tag)
  );

  // mem_req is registered, so each burst opens with one issue cycle; a
  // write-back flows straight into its refill without dropping the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      hit_q     <= 1'b0;
      way_q     <= 1'b0;
      mem_req_q <= 1'b0;
      atag_q    <= '0;
      vtag_q    <= '0;
      idx_q     <= '0;
      cword_q   <= '0;
      bcnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req_valid) begin
            rw_q    <= cpu_rw;
            atag_q  <= cpu_addr[TAG_LSB +: TAG_W];
            idx_q   <= cpu_addr[IDX_LSB +: IDX_W];
            cword_q <= cpu_addr[WORD_LSB +: WORD_W];
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q  <= ts_hit;
          bcnt_q <= '0;
          if (ts_hit) begin
            way_q   <= ts_hit_way;
            state_q <= S_RESPOND;
          end else begin
            way_q   <= ts_victim_way;
            vtag_q  <= ts_victim_tag;
            state_q <= ts_victim_dirty ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK, S_REFILL: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ack) begin
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == LAST_WORD) begin
              if (state_q == S_WRITEBACK) begin
                state_q <= S_REFILL;
              end else begin
                mem_req_q <= 1'b0;
                state_q   <= S_RESPOND;
              end
            end
          end
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_hit        = 1'b0;
    da_en          = 1'b0;
    da_we          = 1'b0;
    da_wsel        = 1'b0;
    da_way         = 1'b0;
    da_set         = '0;
    da_word        = '0;
    mem_req        = mem_req_q;
    mem_we         = mem_req_q && (state_q == S_WRITEBACK);
    mem_addr       = '0;
    if (mem_req_q)
      mem_addr = compose_addr((state_q == S_WRITEBACK) ? vtag_q : atag_q, idx_q, bcnt_q);
    unique case (state_q)
      S_IDLE: cpu_req_ready = 1'b1;
      S_WRITEBACK: begin
        da_en   = 1'b1;
        da_way  = way_q;
        da_set  = idx_q;
        da_word = bcnt_q;
      end
      S_REFILL: begin
        da_en   = mem_req_q && mem_ack;
        da_we   = mem_req_q && mem_ack;
        da_wsel = 1'b1;
        da_way  = way_q;
        da_set  = idx_q;
        da_word = bcnt_q;
      end
      S_RESPOND: begin
        da_en          = 1'b1;
        da_we          = rw_q;
        da_way         = way_q;
        da_set         = idx_q;
        da_word        = cword_q;
        cpu_resp_valid = 1'b1;
        cpu_hit        = hit_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed vector table, delayed-ack and
// mid-burst reset sequences, and random traffic against a behavioural cache model.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cpu_req_valid = 1'b0;
  logic       cpu_rw = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic       cpu_req_ready, cpu_resp_valid, cpu_hit;
  logic       da_en, da_we, da_wsel, da_way, da_set;
  logic [1:0] da_word;
  logic       mem_req, mem_we, mem_ack;
  logic [9:0] mem_addr;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_resp_valid(cpu_resp_valid), .cpu_hit(cpu_hit),
    .da_en(da_en), .da_we(da_we), .da_wsel(da_wsel), .da_way(da_way), .da_set(da_set),
    .da_word(da_word), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks a word after mem_delay waiting cycles; spurious
  // acks may be driven only while no request is outstanding.
  int mem_delay = 0;
  int wait_cnt = 0;
  bit spur_en = 0;
  bit spur_ack = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req && mem_ack) wait_cnt <= 0;
    else if (mem_req) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  assign mem_ack = mem_req ? (wait_cnt >= mem_delay) : spur_ack;
  always @(posedge clk) begin
    #1;
    spur_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: logs completed memory words and checks burst-side strobes.
  int  obs_q[$];
  int  resp_cnt = 0;
  int  stall_err = 0;
  int  strobe_err = 0;
  int  exp_way = 0;
  bit  prev_wait = 0;
  int  prev_op = 0;
  always @(negedge clk) begin
    bit ok;
    if (cpu_resp_valid) resp_cnt++;
    if (rst_n && mem_req) begin
      if (prev_wait && int'({mem_we, mem_addr}) != prev_op) stall_err++;
      prev_wait = !mem_ack;
      prev_op   = int'({mem_we, mem_addr});
      if (mem_ack) begin
        obs_q.push_back(int'({mem_we, mem_addr}));
        ok = da_en && (da_we == !mem_we) && (da_word == mem_addr[3:2]) &&
             (da_set == mem_addr[4]) && (int'(da_way) == exp_way) && (mem_we || da_wsel);
        if (!ok) strobe_err++;
      end
    end else begin
      prev_wait = 0;
    end
  end

  // Behavioural cache: per set, two blocks with tag/valid/dirty and the MRU way.
  int m_tag   [2][2];
  bit m_val   [2][2];
  bit m_dirty [2][2];
  int m_mru   [2];
  int exp_q[$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++) begin
        m_val[s][w] = 0;
        m_dirty[s][w] = 0;
      end
  endtask

  task automatic model_req(input bit rw, input logic [9:0] a, output bit hit, output int way);
    int t, s;
    t = int'(a[9:5]);
    s = int'(a[4]);
    hit = 0;
    way = 0;
    exp_q.delete();
    for (int w = 1; w >= 0; w--)
      if (m_val[s][w] && m_tag[s][w] == t) begin
        hit = 1;
        way = w;
      end
    if (!hit) begin
      if (!m_val[s][0])      way = 0;
      else if (!m_val[s][1]) way = 1;
      else                   way = 1 - m_mru[s];
      if (m_val[s][way] && m_dirty[s][way])
        for (int wd = 0; wd < 4; wd++)
          exp_q.push_back((1 << 10) | (m_tag[s][way] << 5) | (s << 4) | (wd << 2));
      for (int wd = 0; wd < 4; wd++)
        exp_q.push_back((t << 5) | (s << 4) | (wd << 2));
      m_tag[s][way]   = t;
      m_val[s][way]   = 1;
      m_dirty[s][way] = 0;
    end
    if (rw) m_dirty[s][way] = 1;
    m_mru[s] = way;
  endtask

  task automatic do_req(input bit rw, input logic [9:0] a, input bit hold,
                        output bit got_hit, output int lat, output int nwr, output int nrd);
    bit mhit, accepted, got, ready_bad;
    int mway, exp_lat, t0, b_strobe, b_stall, b_resp;
    bit r_en, r_we, r_wsel, r_way, r_set;
    int r_word;
    model_req(rw, a, mhit, mway);
    exp_way  = mway;
    exp_lat  = mhit ? 2 : 3 + exp_q.size() * (mem_delay + 1);
    obs_q.delete();
    b_strobe = strobe_err;
    b_stall  = stall_err;
    b_resp   = resp_cnt;
    got_hit = 0; lat = -1; nwr = 0; nrd = 0; t0 = 0;
    r_en = 0; r_we = 0; r_wsel = 0; r_way = 0; r_set = 0; r_word = 0;
    @(posedge clk); #1;
    cpu_req_valid = 1; cpu_rw = rw; cpu_addr = a;
    accepted = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_req_ready) begin accepted = 1; t0 = cyc; break; end
    end
    chk("accept", int'(accepted), 1);
    @(posedge clk); #1;
    if (hold) begin
      cpu_rw = 1'($urandom); cpu_addr = 10'($urandom);
    end else begin
      cpu_req_valid = 0;
    end
    got = 0; ready_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_req_ready) ready_bad = 1;
      if (cpu_resp_valid) begin
        got = 1; lat = cyc - t0; got_hit = cpu_hit;
        r_en = da_en; r_we = da_we; r_wsel = da_wsel; r_way = da_way;
        r_set = da_set; r_word = int'(da_word);
        break;
      end
    end
    chk("resp_seen", int'(got), 1);
    @(posedge clk); #1;
    cpu_req_valid = 0;
    @(negedge clk);
    foreach (obs_q[i]) if (obs_q[i][10]) nwr++; else nrd++;
    chk("hit_model", int'(got_hit), int'(mhit));
    chk("latency", lat, exp_lat);
    chk("mem_op_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk($sformatf("mem_op[%0d]", i), obs_q[i], exp_q[i]);
    chk("resp_da_en", int'(r_en), 1);
    chk("resp_da_we", int'(r_we), int'(rw));
    chk("resp_da_wsel", int'(r_wsel), 0);
    chk("resp_da_way", int'(r_way), mway);
    chk("resp_da_set", int'(r_set), int'(a[4]));
    chk("resp_da_word", r_word, int'(a[3:2]));
    chk("burst_strobes", strobe_err - b_strobe, 0);
    chk("mem_addr_stable", stall_err - b_stall, 0);
    chk("resp_count", resp_cnt - b_resp, 1);
    if (hold) chk("ready_low_busy", int'(ready_bad), 0);
  endtask

  typedef struct {
    bit         rw;
    logic [9:0] addr;
    bit         hit;
    int         lat;
    int         nwr;
    int         nrd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit h;
    int lat, nwr, nrd, b_resp, nrd_seen;
    logic [9:0] ra;
    vecs[0] = '{0, 10'h000, 0, 7,  0, 4};
    vecs[1] = '{1, 10'h000, 1, 2,  0, 0};
    vecs[2] = '{0, 10'h200, 0, 7,  0, 4};
    vecs[3] = '{0, 10'h000, 1, 2,  0, 0};
    vecs[4] = '{0, 10'h300, 0, 7,  0, 4};
    vecs[5] = '{0, 10'h200, 0, 11, 4, 4};

    #1 rst_n = 0;
    #2;
    chk("rst_ready", int'(cpu_req_ready), 1);
    chk("rst_resp_valid", int'(cpu_resp_valid), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_da", int'({da_en, da_we, da_wsel, da_way, da_set, da_word}), 0);
    chk("rst_mem_addr", int'({mem_we, mem_addr}), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    mem_delay = 0;
    for (int i = 0; i < 6; i++) begin
      do_req(vecs[i].rw, vecs[i].addr, 0, h, lat, nwr, nrd);
      chk($sformatf("vec%0d_hit", i), int'(h), int'(vecs[i].hit));
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_nwr", i), nwr, vecs[i].nwr);
      chk($sformatf("vec%0d_nrd", i), nrd, vecs[i].nrd);
    end

    mem_delay = 3;
    do_req(0, 10'h040, 1, h, lat, nwr, nrd);
    chk("slow_hit", int'(h), 0);
    chk("slow_lat", lat, 19);

    spur_en = 1;
    for (int i = 0; i < 60; i++) begin
      mem_delay = $urandom_range(0, 2);
      ra = {3'b000, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 2'b00};
      do_req(1'($urandom), ra, 1'($urandom), h, lat, nwr, nrd);
    end
    spur_en = 0;

    mem_delay = 1;
    obs_q.delete();
    exp_way = 0;
    @(posedge clk); #1;
    cpu_req_valid = 1; cpu_rw = 0; cpu_addr = 10'h100;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req_valid = 0;
    nrd_seen = 0;
    for (int i = 0; i < 100 && nrd_seen < 2; i++) begin
      @(negedge clk);
      nrd_seen = 0;
      foreach (obs_q[k]) if (!obs_q[k][10]) nrd_seen++;
    end
    chk("midrefill_reached", nrd_seen, 2);
    b_resp = resp_cnt;
    @(posedge clk); #1;
    chk("midrefill_req_before", int'(mem_req), 1);
    rst_n = 0;
    #1;
    chk("midrefill_req_drop", int'(mem_req), 0);
    chk("midrefill_ready", int'(cpu_req_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("midrefill_no_resp", resp_cnt - b_resp, 0);
    model_reset();
    mem_delay = 0;
    do_req(0, 10'h200, 0, h, lat, nwr, nrd);
    chk("after_reset_miss", int'(h), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
